// File: rtl/sprite_pkg.sv
// Shared types and constants for the multi-sprite renderer: frame-table descriptor,
// signed screen-coordinate helpers and the default animation-state table.
package sprite_pkg;

  localparam int COORD_W          = 10;
  localparam int S_W              = COORD_W + 2;
  localparam int STATE_W          = 6;
  localparam int TBL_IDX_W        = 5;
  localparam int PIX_TRANSPARENT  = 0;
  localparam int ADDR_W_DEF       = 19;
  localparam int PIX_W_DEF        = 3;
  localparam int SHEET_LENGTH_DEF = 502;
  localparam int SHEET_WIDTH_DEF  = 424;
  localparam int NUM_STATES_DEF   = 17;

  typedef logic signed [S_W-1:0] scoord_t;

  typedef struct packed {
    logic [COORD_W-1:0] center_x;
    logic [COORD_W-1:0] center_y;
    logic [COORD_W-1:0] corner_x;
    logic [COORD_W-1:0] corner_y;
    logic [COORD_W-1:0] frame_x;
    logic [COORD_W-1:0] frame_y;
  } frame_desc_t;

  function automatic scoord_t to_scoord(input logic [COORD_W-1:0] c);
    return $signed({2'b00, c});
  endfunction

  // {CenterX, CenterY, CornerX, CornerY, FrameX, FrameY} per animation state
  localparam frame_desc_t DEFAULT_TABLE [NUM_STATES_DEF] = '{
    '{10'd69, 10'd22, 10'd0,   10'd0,   10'd106, 10'd108},
    '{10'd60, 10'd20, 10'd110, 10'd0,   10'd100, 10'd104},
    '{10'd55, 10'd25, 10'd215, 10'd0,   10'd96,  10'd110},
    '{10'd50, 10'd18, 10'd315, 10'd0,   10'd90,  10'd100},
    '{10'd70, 10'd22, 10'd410, 10'd0,   10'd88,  10'd106},
    '{10'd65, 10'd20, 10'd0,   10'd115, 10'd104, 10'd100},
    '{10'd60, 10'd24, 10'd110, 10'd115, 10'd98,  10'd108},
    '{10'd52, 10'd20, 10'd215, 10'd115, 10'd94,  10'd102},
    '{10'd48, 10'd22, 10'd315, 10'd115, 10'd92,  10'd104},
    '{10'd66, 10'd26, 10'd410, 10'd115, 10'd86,  10'd110},
    '{10'd62, 10'd20, 10'd0,   10'd230, 10'd100, 10'd96},
    '{10'd58, 10'd22, 10'd110, 10'd230, 10'd102, 10'd100},
    '{10'd54, 10'd18, 10'd215, 10'd230, 10'd96,  10'd104},
    '{10'd50, 10'd24, 10'd315, 10'd230, 10'd90,  10'd98},
    '{10'd68, 10'd20, 10'd410, 10'd230, 10'd88,  10'd100},
    '{10'd64, 10'd22, 10'd0,   10'd335, 10'd106, 10'd86},
    '{10'd56, 10'd20, 10'd110, 10'd335, 10'd100, 10'd88}
  };

endpackage

// File: rtl/sprite_channel.sv
// One sprite channel: bounding-box test against the current frame descriptor and
// sprite-sheet address generation, registered as pipeline stage 1.
module sprite_channel
  import sprite_pkg::*;
#(
  parameter int SHEET_LENGTH = SHEET_LENGTH_DEF,
  parameter int ADDR_W       = ADDR_W_DEF
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic               mirror_i,
  input  logic               desc_ok_i,
  input  logic [COORD_W-1:0] draw_x_i,
  input  logic [COORD_W-1:0] draw_y_i,
  input  logic [COORD_W-1:0] anchor_x_i,
  input  logic [COORD_W-1:0] anchor_y_i,
  input  frame_desc_t        desc_i,
  output logic               cand_o,
  output logic [ADDR_W-1:0]  rom_addr_o
);

  localparam logic [ADDR_W-1:0] PITCH = ADDR_W'(SHEET_LENGTH);

  scoord_t           dx, left, top, u, v;
  logic [ADDR_W-1:0] row, col, addr_d, addr_q;
  logic              cand_d, cand_q;

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    dx     = '0;
    row    = '0;
    col    = '0;
    addr_d = '0;
    if (mirror_i)
      dx = to_scoord(desc_i.center_x)
         - (to_scoord(desc_i.corner_x) + to_scoord(desc_i.frame_x) - S_W'(1));
    else
      dx = to_scoord(desc_i.corner_x) - to_scoord(desc_i.center_x);
    left = to_scoord(anchor_x_i) + dx;
    top  = to_scoord(anchor_y_i) + to_scoord(desc_i.corner_y) - to_scoord(desc_i.center_y);
    u    = to_scoord(draw_x_i) - left;
    v    = to_scoord(draw_y_i) - top;
    // Signed u/v make a box hanging off the left/top edge clip instead of wrapping.
    cand_d = en_i && desc_ok_i
          && !u[S_W-1] && (u < to_scoord(desc_i.frame_x))
          && !v[S_W-1] && (v < to_scoord(desc_i.frame_y));
    row = ADDR_W'(desc_i.corner_y) + ADDR_W'(v[COORD_W-1:0]);
    if (mirror_i)
      col = ADDR_W'(desc_i.corner_x) + ADDR_W'(desc_i.frame_x) - ADDR_W'(1)
          - ADDR_W'(u[COORD_W-1:0]);
    else
      col = ADDR_W'(desc_i.corner_x) + ADDR_W'(u[COORD_W-1:0]);
    if (cand_d)
      addr_d = row * PITCH + col;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cand_q <= 1'b0;
      addr_q <= '0;
    end else begin
      cand_q <= cand_d;
      addr_q <= addr_d;
    end
  end

  assign cand_o     = cand_q;
  assign rom_addr_o = addr_q;

endmodule

// File: rtl/sprite_renderer.sv
// Multi-sprite pixel renderer: frame-latched sprite shadows, writable frame table,
// per-sprite ROM address channels and a fixed-priority transparent merge (3-cycle latency).
module sprite_renderer
  import sprite_pkg::*;
#(
  parameter int NUM_SPRITES  = 2,
  parameter int NUM_STATES   = NUM_STATES_DEF,
  parameter int SHEET_LENGTH = SHEET_LENGTH_DEF,
  parameter int SHEET_WIDTH  = SHEET_WIDTH_DEF,
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int PIX_W        = PIX_W_DEF,
  localparam int ID_W        = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  frame_start_i,
  input  logic                                  pix_in_valid_i,
  input  logic [COORD_W-1:0]                    draw_x_i,
  input  logic [COORD_W-1:0]                    draw_y_i,
  input  logic [NUM_SPRITES-1:0]                sprite_en_i,
  input  logic [NUM_SPRITES-1:0]                sprite_mirror_i,
  input  logic [NUM_SPRITES-1:0][COORD_W-1:0]   sprite_x_i,
  input  logic [NUM_SPRITES-1:0][COORD_W-1:0]   sprite_y_i,
  input  logic [NUM_SPRITES-1:0][STATE_W-1:0]   sprite_state_i,
  input  logic                                  tbl_we_i,
  input  logic [TBL_IDX_W-1:0]                  tbl_idx_i,
  input  frame_desc_t                           tbl_wdata_i,
  output logic [NUM_SPRITES-1:0][ADDR_W-1:0]    rom_addr_o,
  input  logic [NUM_SPRITES-1:0][PIX_W-1:0]     rom_data_i,
  output logic                                  pix_out_valid_o,
  output logic                                  pix_hit_o,
  output logic [ID_W-1:0]                       pix_id_o,
  output logic [PIX_W-1:0]                      pix_data_o
);

  if (SHEET_LENGTH * SHEET_WIDTH > (1 << ADDR_W)) begin : g_sheet_too_large
    $error("sprite sheet does not fit in ADDR_W address bits");
  end

  logic [NUM_SPRITES-1:0]              en_q, mirror_q;
  logic [NUM_SPRITES-1:0][COORD_W-1:0] x_q, y_q;
  logic [NUM_SPRITES-1:0][STATE_W-1:0] state_q;
  frame_desc_t                         tbl_q [NUM_STATES];
  frame_desc_t                         desc  [NUM_SPRITES];
  logic [NUM_SPRITES-1:0]              desc_ok, cand1, cand2_q;
  logic                                valid1_q, valid2_q, valid3_q;
  logic                                hit_d, hit_q;
  logic [ID_W-1:0]                     id_d, id_q;
  logic [PIX_W-1:0]                    data_d, data_q;

  // Pixels in the frame_start cycle still see the old shadows.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      en_q     <= '0;
      mirror_q <= '0;
      x_q      <= '0;
      y_q      <= '0;
      state_q  <= '0;
    end else if (frame_start_i) begin
      en_q     <= sprite_en_i;
      mirror_q <= sprite_mirror_i;
      x_q      <= sprite_x_i;
      y_q      <= sprite_y_i;
      state_q  <= sprite_state_i;
    end
  end

  // NOTE: the table is a small register file that must start all-zero, so it is reset; large RAMs normally are not.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int j = 0; j < NUM_STATES; j++) tbl_q[j] <= '0;
    end else if (tbl_we_i) begin
      for (int j = 0; j < NUM_STATES; j++)
        if (tbl_idx_i == TBL_IDX_W'(j)) tbl_q[j] <= tbl_wdata_i;
    end
  end

  // States at or beyond NUM_STATES match no entry and leave desc_ok low.
  always_comb begin
    for (int i = 0; i < NUM_SPRITES; i++) begin
      desc[i]    = '0;
      desc_ok[i] = 1'b0;
      for (int j = 0; j < NUM_STATES; j++) begin
        if (state_q[i] == STATE_W'(j)) begin
          desc[i]    = tbl_q[j];
          desc_ok[i] = 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_channel
    sprite_channel #(
      .SHEET_LENGTH (SHEET_LENGTH),
      .ADDR_W       (ADDR_W)
    ) u_channel (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .en_i       (en_q[g]),
      .mirror_i   (mirror_q[g]),
      .desc_ok_i  (desc_ok[g]),
      .draw_x_i   (draw_x_i),
      .draw_y_i   (draw_y_i),
      .anchor_x_i (x_q[g]),
      .anchor_y_i (y_q[g]),
      .desc_i     (desc[g]),
      .cand_o     (cand1[g]),
      .rom_addr_o (rom_addr_o[g])
    );
  end

  // Descending scan: the last assignment, i.e. the lowest opaque index, wins.
  always_comb begin
    hit_d  = 1'b0;
    id_d   = '0;
    data_d = '0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (valid2_q && cand2_q[i] && rom_data_i[i] != PIX_W'(PIX_TRANSPARENT)) begin
        hit_d  = 1'b1;
        id_d   = ID_W'(i);
        data_d = rom_data_i[i];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid1_q <= 1'b0;
      valid2_q <= 1'b0;
      valid3_q <= 1'b0;
      cand2_q  <= '0;
      hit_q    <= 1'b0;
      id_q     <= '0;
      data_q   <= '0;
    end else begin
      valid1_q <= pix_in_valid_i;
      valid2_q <= valid1_q;
      valid3_q <= valid2_q;
      cand2_q  <= cand1;
      hit_q    <= hit_d;
      id_q     <= id_d;
      data_q   <= data_d;
    end
  end

  assign pix_out_valid_o = valid3_q;
  assign pix_hit_o       = hit_q;
  assign pix_id_o        = id_q;
  assign pix_data_o      = data_q;

endmodule

// File: tb/tb_sprite_renderer.sv
// Self-checking bench for sprite_renderer: directed edge cases plus randomized pixels,
// compared against a per-pixel bounding-box/priority model and a synchronous ROM model.
module tb_sprite_renderer;
  import sprite_pkg::*;

  localparam int NS  = 2;
  localparam int NST = 17;
  localparam int AW  = 19;
  localparam int PW  = 3;
  localparam int SL  = 502;

  typedef struct {
    bit v;
    bit cand [NS];
    int addr [NS];
    bit hit;
    int id;
    int data;
  } exp_t;

  logic                        clk = 1'b0;
  logic                        rst;
  logic                        frame_start, pix_in_valid, tbl_we;
  logic [COORD_W-1:0]          draw_x, draw_y;
  logic [NS-1:0]               sprite_en, sprite_mirror;
  logic [NS-1:0][COORD_W-1:0]  sprite_x, sprite_y;
  logic [NS-1:0][STATE_W-1:0]  sprite_state;
  logic [TBL_IDX_W-1:0]        tbl_idx;
  frame_desc_t                 tbl_wdata;
  logic [NS-1:0][AW-1:0]       rom_addr;
  logic [NS-1:0][PW-1:0]       rom_data = '0;
  logic                        pix_out_valid, pix_hit;
  logic [0:0]                  pix_id;
  logic [PW-1:0]               pix_data;

  int vectors = 0;
  int miscompares = 0;
  int rom_const [NS];
  int m_en [NS], m_mir [NS], m_x [NS], m_y [NS], m_st [NS];
  frame_desc_t m_tbl [NST];
  exp_t e1, e2, e3;

  sprite_renderer #(
    .NUM_SPRITES (NS), .NUM_STATES (NST), .SHEET_LENGTH (SL),
    .SHEET_WIDTH (424), .ADDR_W (AW), .PIX_W (PW)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .frame_start_i   (frame_start),
    .pix_in_valid_i  (pix_in_valid),
    .draw_x_i        (draw_x),
    .draw_y_i        (draw_y),
    .sprite_en_i     (sprite_en),
    .sprite_mirror_i (sprite_mirror),
    .sprite_x_i      (sprite_x),
    .sprite_y_i      (sprite_y),
    .sprite_state_i  (sprite_state),
    .tbl_we_i        (tbl_we),
    .tbl_idx_i       (tbl_idx),
    .tbl_wdata_i     (tbl_wdata),
    .rom_addr_o      (rom_addr),
    .rom_data_i      (rom_data),
    .pix_out_valid_o (pix_out_valid),
    .pix_hit_o       (pix_hit),
    .pix_id_o        (pix_id),
    .pix_data_o      (pix_data)
  );

  always #5 clk = ~clk;

  // Sprite-sheet contents: a fixed value per sprite, or an address hash with ~1/8 transparent.
  function automatic int rom_fn(input int i, input int a);
    if (rom_const[i] >= 0) return rom_const[i];
    return (a * 5 + (a >> 3) + i) & 7;
  endfunction

  always @(posedge clk)
    for (int i = 0; i < NS; i++) rom_data[i] <= PW'(rom_fn(i, int'(rom_addr[i])));

  function automatic void box(input int i, output int left, output int top);
    frame_desc_t t = m_tbl[m_st[i]];
    if (m_mir[i] != 0)
      left = m_x[i] + int'(t.center_x) - (int'(t.corner_x) + int'(t.frame_x) - 1);
    else
      left = m_x[i] + int'(t.corner_x) - int'(t.center_x);
    top = m_y[i] + int'(t.corner_y) - int'(t.center_y);
  endfunction

  function automatic void calc(input int i, input int px, input int py,
                               output bit c, output int a);
    frame_desc_t t;
    int left, top, u, v, col;
    c = 0;
    a = 0;
    if (m_en[i] == 0 || m_st[i] >= NST) return;
    t = m_tbl[m_st[i]];
    box(i, left, top);
    u = px - left;
    v = py - top;
    if (u < 0 || u >= int'(t.frame_x) || v < 0 || v >= int'(t.frame_y)) return;
    col = (m_mir[i] != 0) ? int'(t.corner_x) + int'(t.frame_x) - 1 - u : int'(t.corner_x) + u;
    c = 1;
    a = ((int'(t.corner_y) + v) * SL + col) % (1 << AW);
  endfunction

  function automatic exp_t resolve(input exp_t e);
    e.hit = 0; e.id = 0; e.data = 0;
    if (e.v)
      for (int i = 0; i < NS; i++)
        if (!e.hit && e.cand[i] && rom_fn(i, e.addr[i]) != 0) begin
          e.hit = 1; e.id = i; e.data = rom_fn(i, e.addr[i]);
        end
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < NS; i++) begin
      m_en[i] = 0; m_mir[i] = 0; m_x[i] = 0; m_y[i] = 0; m_st[i] = 0;
    end
    for (int j = 0; j < NST; j++) m_tbl[j] = '0;
    e1.v = 0; e2.v = 0; e3.v = 0;
  endtask

  // One clock: predict this cycle's pixel, advance the model, check stage-1 and stage-3 outputs.
  task automatic tick();
    exp_t now;
    bit c;
    int a;
    now.v = pix_in_valid;
    now.hit = 0; now.id = 0; now.data = 0;
    for (int i = 0; i < NS; i++) begin
      c = 0; a = 0;
      if (pix_in_valid) calc(i, int'(draw_x), int'(draw_y), c, a);
      now.cand[i] = c;
      now.addr[i] = a;
    end
    @(posedge clk);
    if (frame_start)
      for (int i = 0; i < NS; i++) begin
        m_en[i] = int'(sprite_en[i]); m_mir[i] = int'(sprite_mirror[i]);
        m_x[i] = int'(sprite_x[i]); m_y[i] = int'(sprite_y[i]); m_st[i] = int'(sprite_state[i]);
      end
    if (tbl_we && int'(tbl_idx) < NST) m_tbl[int'(tbl_idx)] = tbl_wdata;
    e3 = e2;
    e2 = resolve(e1);
    e1 = now;
    #1;
    check("out_valid", pix_out_valid, e3.v);
    if (e3.v) begin
      check("out_hit", pix_hit, e3.hit);
      check("out_id", pix_id, e3.id);
      check("out_data", pix_data, e3.data);
    end
    if (e1.v)
      for (int i = 0; i < NS; i++) check($sformatf("rom_addr%0d", i), rom_addr[i], e1.addr[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic pixel(input int px, input int py);
    pix_in_valid = 1'b1;
    draw_x = COORD_W'(px);
    draw_y = COORD_W'(py);
    tick();
    pix_in_valid = 1'b0;
  endtask

  task automatic write_tbl(input int idx, input frame_desc_t d);
    tbl_we = 1'b1; tbl_idx = TBL_IDX_W'(idx); tbl_wdata = d;
    tick();
    tbl_we = 1'b0;
  endtask

  task automatic set_sprite(input int i, input bit en, input bit mir, input int x, input int y,
                            input int st);
    sprite_en[i] = en; sprite_mirror[i] = mir;
    sprite_x[i] = COORD_W'(x); sprite_y[i] = COORD_W'(y); sprite_state[i] = STATE_W'(st);
  endtask

  task automatic latch();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic rand_sprite(input int i);
    set_sprite(i, $urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)),
               $urandom_range(60, 900), $urandom_range(40, 440), $urandom_range(0, 19));
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic reset_dut();
    rst = 1'b1;
    #1;
    check("rst_valid", pix_out_valid, 0);
    check("rst_hit", pix_hit, 0);
    check("rst_id", pix_id, 0);
    check("rst_data", pix_data, 0);
    for (int i = 0; i < NS; i++) check($sformatf("rst_addr%0d", i), rom_addr[i], 0);
    clear_model();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int left, top, j, px, py;
    frame_desc_t d;
    rst = 1'b1; frame_start = 1'b0; pix_in_valid = 1'b0; tbl_we = 1'b0;
    draw_x = '0; draw_y = '0; tbl_idx = '0; tbl_wdata = '0;
    sprite_en = '0; sprite_mirror = '0; sprite_x = '0; sprite_y = '0; sprite_state = '0;
    rom_const[0] = 4; rom_const[1] = -1;
    clear_model();
    repeat (2) @(posedge clk);
    reset_dut();

    // Top-left texel, then one past the right edge.
    write_tbl(0, DEFAULT_TABLE[0]);
    set_sprite(0, 1, 0, 300, 200, 0);
    latch();
    pixel(231, 178);
    check("tl_addr", rom_addr[0], 0);
    pixel(337, 178);
    idle(1);
    check("tl_hit", pix_hit, 1);
    check("tl_data", pix_data, 4);
    idle(1);
    check("right_edge_miss", pix_hit, 0);

    // Mirrored: left edge of the box reads the last sheet column.
    set_sprite(0, 1, 1, 300, 200, 0);
    latch();
    pixel(264, 178);
    check("mirror_addr", rom_addr[0], 105);
    idle(2);
    check("mirror_hit", pix_hit, 1);

    // Clipped at the left screen edge; no wrap-around hits near 1023.
    set_sprite(0, 1, 0, 10, 200, 0);
    latch();
    pixel(0, 178);
    check("clip_addr", rom_addr[0], 59);
    pixel(1000, 178);
    pixel(1023, 178);
    check("clip_hit", pix_hit, 1);
    idle(1);
    check("wrap_miss_a", pix_hit, 0);
    idle(1);
    check("wrap_miss_b", pix_hit, 0);
    set_sprite(0, 1, 0, 1000, 200, 0);
    latch();
    pixel(5, 178);
    check("right_wrap_addr", rom_addr[0], 0);
    idle(3);

    // Overlap: transparent sprite 0 lets sprite 1 through; opaque sprite 0 wins.
    set_sprite(0, 1, 0, 300, 200, 0);
    set_sprite(1, 1, 0, 300, 200, 0);
    latch();
    rom_const[0] = 0; rom_const[1] = 5;
    pixel(250, 190);
    idle(2);
    check("ovl_id_a", pix_id, 1);
    check("ovl_data_a", pix_data, 5);
    rom_const[0] = 3;
    pixel(250, 190);
    idle(2);
    check("ovl_id_b", pix_id, 0);
    check("ovl_data_b", pix_data, 3);

    // Shadow registers: live input ignored until frame_start; frame_start pixel uses old x.
    rom_const[0] = 2; rom_const[1] = 6;
    set_sprite(1, 0, 0, 300, 200, 0);
    latch();
    sprite_x[0] = COORD_W'(600);
    pixel(250, 190);
    idle(2);
    check("shadow_hold", pix_hit, 1);
    frame_start = 1'b1;
    pixel(250, 190);
    frame_start = 1'b0;
    pixel(250, 190);
    idle(1);
    check("fs_same_cycle_old", pix_hit, 1);
    idle(1);
    check("fs_next_cycle_new", pix_hit, 0);
    pixel(550, 190);
    idle(3);

    // Invalid state and disabled sprite never hit; table write visible on the next pixel.
    set_sprite(0, 1, 0, 300, 200, 20);
    latch();
    pixel(250, 190);
    idle(2);
    check("bad_state_miss", pix_hit, 0);
    set_sprite(0, 0, 0, 300, 200, 0);
    latch();
    pixel(250, 190);
    idle(2);
    check("disabled_miss", pix_hit, 0);
    set_sprite(0, 1, 0, 300, 200, 0);
    latch();
    d = DEFAULT_TABLE[0];
    d.frame_x = '0;
    write_tbl(0, d);
    pixel(250, 190);
    idle(2);
    check("tbl_update_miss", pix_hit, 0);

    // Reset in the middle of a pixel stream.
    write_tbl(0, DEFAULT_TABLE[0]);
    pixel(250, 190);
    pixel(251, 190);
    reset_dut();
    idle(4);
    pixel(250, 190);
    idle(2);
    check("post_rst_valid", pix_out_valid, 1);
    check("post_rst_miss", pix_hit, 0);

    // Randomized frames over the full default table.
    rom_const[0] = -1; rom_const[1] = -1;
    for (int s = 0; s < NST; s++) write_tbl(s, DEFAULT_TABLE[s]);
    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < NS; i++) rand_sprite(i);
      latch();
      for (int k = 0; k < 80; k++) begin
        j = $urandom_range(0, NS - 1);
        px = $urandom_range(0, 1023);
        py = $urandom_range(0, 479);
        if (m_en[j] != 0 && m_st[j] < NST) begin
          box(j, left, top);
          px = left + $urandom_range(0, int'(m_tbl[m_st[j]].frame_x) + 40) - 20;
          py = top + $urandom_range(0, int'(m_tbl[m_st[j]].frame_y) + 40) - 20;
        end
        if (px < 0) px = 0;
        if (px > 1023) px = 1023;
        if (py < 0) py = 0;
        if (py > 1023) py = 1023;
        if (k % 17 == 5) begin
          rand_sprite($urandom_range(0, NS - 1));
          frame_start = 1'b1;
        end
        if (k % 23 == 11) begin
          tbl_we = 1'b1;
          tbl_idx = TBL_IDX_W'($urandom_range(0, 31));
          tbl_wdata = DEFAULT_TABLE[$urandom_range(0, NST - 1)];
        end
        pix_in_valid = ($urandom_range(0, 7) != 0);
        draw_x = COORD_W'(px);
        draw_y = COORD_W'(py);
        tick();
        frame_start = 1'b0;
        tbl_we = 1'b0;
        pix_in_valid = 1'b0;
      end
      idle(3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sprite_renderer.md
# sprite_renderer

Parametrised multi-sprite pixel renderer for the badminton display path. Per VGA pixel it tests NUM_SPRITES stick-figure sprites against per-state bounding boxes from a runtime-writable frame table, issues one sprite-sheet ROM read per sprite, drops transparent texels, and merges by fixed priority into one registered pixel. It sits between the figure FSM/motion blocks and the colour mapper, and adds horizontal mirroring, frame-boundary latching of sprite inputs, signed clipping at screen edges, and a pipelined valid strobe.

## Interface
- NUM_SPRITES, 2, number of sprite channels; channel 0 has highest priority
- NUM_STATES, 17, frame-table entries (animation states)
- SHEET_LENGTH, 502, sprite-sheet row pitch in texels
- SHEET_WIDTH, 424, sprite-sheet rows
- COORD_W, 10, screen and sheet coordinate width
- ADDR_W, 19, ROM address width
- PIX_W, 3, texel colour-index width; index 0 is transparent
- Clk  in  1  system clock, 50 MHz
- Reset  in  1  asynchronous, active-high
- frame_start  in  1  one-cycle pulse at vertical blank; latches sprite inputs
- pix_in_valid  in  1  DrawX/DrawY valid this cycle
- DrawX, DrawY  in  COORD_W  current pixel
- sprite_en  in  NUM_SPRITES  per-sprite enable
- sprite_mirror  in  NUM_SPRITES  1 = flip horizontally (right-side player)
- sprite_x, sprite_y  in  NUM_SPRITES×COORD_W  anchor (state centre) screen position
- sprite_state  in  NUM_SPRITES×6  animation state index
- tbl_we  in  1  frame-table write strobe
- tbl_idx  in  5  entry written
- tbl_wdata  in  6×COORD_W  {CenterX, CenterY, CornerX, CornerY, FrameX, FrameY}
- rom_addr  out  NUM_SPRITES×ADDR_W  registered ROM read addresses
- rom_data  in  NUM_SPRITES×PIX_W  synchronous-ROM data, one cycle after rom_addr
- pix_out_valid  out  1  output pixel valid
- pix_hit  out  1  an opaque sprite texel covers the pixel
- pix_id  out  clog2(NUM_SPRITES)  winning sprite
- pix_data  out  PIX_W  winning texel; 0 when no hit

## Operation
- Shadow registers: sprite_en/mirror/x/y/state copied when frame_start=1; live inputs otherwise ignored. Reset clears shadows (all sprites disabled).
- Frame table: NUM_STATES registered entries, reset to all zero (FrameX=FrameY=0 yields no hit). Write on tbl_we; tbl_idx ≥ NUM_STATES ignored.
- Per sprite, signed arithmetic at COORD_W+2 bits: dx = Kx − Cx (normal) or Cx − (Kx+Fx−1) (mirror); left = x + dx; top = y + (Ky − Cy); u = DrawX − left; v = DrawY − top.
- Hit candidate iff enabled, state < NUM_STATES, 0 ≤ u < Fx, 0 ≤ v < Fy. Negative left/top is legal (partial clip at left/top screen edges); no wrap-around.
- Sheet column = Kx + u (normal) or Kx + Fx−1−u (mirror); rom_addr = (Ky+v)·SHEET_LENGTH + column, truncated to ADDR_W. Non-candidates drive rom_addr = 0.
- Merge: lowest-index sprite that is a candidate with rom_data ≠ 0 wins; a transparent texel lets lower-priority sprites show.

## Timing
- Stage 1 (edge after input): candidate flags, rom_addr, valid registered.
- Stage 2: ROM returns rom_data; candidate flags and valid delayed one stage.
- Stage 3: merge registered to pix_out_valid/pix_hit/pix_id/pix_data.
- Latency 3 cycles pix_in_valid → pix_out_valid; one pixel per cycle, no stalls.
- Reset values: all outputs 0, all pipeline valids 0. Reset mid-frame flushes the pipeline; output stays invalid until new inputs arrive.
- frame_start and pix_in_valid in the same cycle: that pixel uses the old shadow values; new values apply from the next cycle.
- tbl_we to an entry in use: visible to pixels entering one cycle after the write.

## Structure
- Package sprite_pkg: frame_desc_t struct (six COORD_W fields), PIX_TRANSPARENT = 0, default sheet constants, default 17-entry state table used by the bench.
- Sub-module sprite_channel: one instance per sprite, containing the bounding test and address generation (stage 1). The top level holds shadows, the frame table, stage 2 delay and the priority merge.

## Test plan
- Reset, write state 0 = {69,22,0,0,106,108}, sprite 0 at (300,200), frame_start; DrawX=231, DrawY=178 → rom_addr0 = 0, pix_hit after 3 cycles if ROM is nonzero; DrawX=337 → no hit.
- Same setup with mirror=1: DrawX=(300−36)=264, DrawY=178 → rom_addr0 = 105 (column Kx+Fx−1).
- Sprite 0 at x=10 (left = −59): DrawX=0, DrawY=178 → column 59, hit; no false hit at DrawX=1000-range wrap values.
- Both sprites overlap, ROM0=0 and ROM1=5 → pix_id=1, pix_data=5; ROM0=3 → pix_id=0, pix_data=3.
- Change sprite_x without frame_start → output unchanged; pulse frame_start together with pix_in_valid → that pixel uses old x, the next pixel uses new x.
- Assert Reset during streaming → all outputs 0 immediately, pix_out_valid low until 3 cycles after the next valid pixel; state=20 or sprite_en=0 → never hits.
